fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the MIPS pipeline, directly upstream of the main decoder.
- Owns the PC and issues word reads to instruction memory over a req/gnt/rvalid handshake with at most one request outstanding.
- Holds the fetched word in an IF/ID register and presents the opcode and funct fields to the decoder.
- Supports decode stalls and jump/branch redirects, including squashing an in-flight fetch.

Parameters:
- RESET_PC, 32'h0040_0000, first fetch address after reset
- ADDR_W, 32, PC / memory address width

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_req_o  out  1  fetch request
- imem_addr_o  out  ADDR_W  word address of request, bits [1:0] always 0
- imem_gnt_i  in  1  request accepted this cycle
- imem_rvalid_i  in  1  response valid, at least 1 cycle after gnt
- imem_rdata_i  in  32  instruction word
- id_stall_i  in  1  decode cannot accept; hold IF/ID
- redirect_i  in  1  jump/branch taken; flush and refetch
- redirect_pc_i  in  ADDR_W  redirect target; bits [1:0] ignored
- instr_o  out  32  IF/ID instruction
- instr_op_o  out  6  instr_o[31:26] to decoder
- instr_funct_o  out  6  instr_o[5:0] to decoder
- pc_o  out  ADDR_W  PC of instr_o
- pc_plus4_o  out  ADDR_W  pc_o + 4, for link/branch base
- instr_valid_o  out  1  IF/ID holds a live instruction

Behaviour:
- Reset, asynchronous on rst_n low:
  - state=IDLE, pc_q=RESET_PC, kill=0, hold buffer empty.
  - instr_o=32'h0 (NOP), pc_o=0, instr_valid_o=0, imem_req_o=0.
  - Reset mid-fetch abandons the transaction; any late rvalid after reset release while not in WAIT is ignored.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
- IDLE:
  - Goes to ISSUE on the next cycle.
- ISSUE:
  - imem_req_o=1, imem_addr_o=pc_q.
  - On gnt, go to WAIT.
  - Address may change without gnt only on redirect; the request is withdrawn and re-issued with the new PC.
- WAIT:
  - On rvalid with kill=1: drop the data, clear kill, go to ISSUE.
  - On rvalid with kill=0 and (!id_stall_i or !instr_valid_o): load IF/ID (instr, pc_q, valid=1), pc_q+=4, go to ISSUE.
  - On rvalid with kill=0 and the stall blocking: capture the data in the hold buffer, go to HOLD.
- HOLD:
  - When id_stall_i=0, move the buffer into IF/ID, pc_q+=4, go to ISSUE.
- Latency:
  - Fetched word appears on instr_o the cycle after rvalid.
  - Back-to-back throughput is 1 instruction per 2 cycles with single-cycle memory (gnt then rvalid).
- IF/ID stall:
  - id_stall_i=1 with instr_valid_o=1 holds instr_o, pc_o and instr_valid_o unchanged.
  - If the decoder drains (stall=0) with no new instruction available, instr_valid_o drops to 0 and instr_o becomes 0.
- Redirect (highest priority, overrides stall, rvalid and hold):
  - Next cycle: pc_q={redirect_pc_i[31:2],2'b00}, IF/ID flushed (valid=0, instr=0), hold buffer cleared.
  - In WAIT, or in ISSUE with gnt the same cycle: set kill=1, go to WAIT.
  - Otherwise go to ISSUE.
  - Redirect with rvalid in the same cycle: the response is dropped and kill is not set.
  - Redirect while kill=1 already: kill stays 1, and only one response is discarded.
- PC wrap: 32'hFFFF_FFFC + 4 = 32'h0000_0000, no flag.
- pc_plus4_o is combinational from pc_o and wraps identically.
- instr_op_o and instr_funct_o are pure slices of instr_o. A flushed or empty slot decodes as SLL $0 (NOP).

Decomposition:
- Shared defines header holds:
  - fetch FSM state encodings (2-bit)
  - NOP encoding 32'h0000_0000
  - RESET_PC default
- Natural sub-module: if_id_reg. It holds the instr/pc/valid registers with load, hold (stall) and flush inputs, async active-low reset, and is reused for later pipeline registers.
- The FSM, PC, kill flag and hold buffer stay in fetch_stage.

Test Plan:
- Reset release, memory gnt same cycle, rvalid next cycle, words A0,A1,A2 -> addresses 0x00400000, 0x00400004, 0x00400008 issued; instr_o sequence A0,A1,A2 with matching pc_o; instr_valid_o=1 one cycle after each rvalid.
- id_stall_i=1 for 5 cycles while the next rvalid arrives -> instr_o holds the old word; FSM in HOLD; no new req; after stall drops, new word appears next cycle; pc_q advanced exactly once.
- redirect_i=1 with target 0x00400103 while in WAIT; old rvalid arrives 3 cycles later -> old data never reaches instr_o; next request address 0x00400100; instr_valid_o=0 until the new response.
- redirect_i with rvalid in the same cycle, plus id_stall_i=1 -> IF/ID flushed to valid=0 / instr 0; kill not set; next fetch at the target.
- pc_q=0xFFFFFFFC fetch completes -> next imem_addr_o=0x00000000; pc_plus4_o=0x00000000 while pc_o=0xFFFFFFFC.
- rst_n asserted mid-WAIT -> all outputs return to reset values immediately; first request after release is at RESET_PC; stray rvalid while in IDLE is ignored.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encodings,
// the NOP word and the default reset PC.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } fetch_state_t;

    // SLL $0,$0,0 -- an empty pipeline slot decodes as this
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// Pipeline register holding instruction, PC and valid bit. Flush beats
// load, load beats hold, and an unstalled register with nothing new empties.
module fetch_stage_if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_stall,
    input  logic              i_flush,
    input  logic [31:0]       i_instr,
    input  logic [ADDR_W-1:0] i_pc,
    output logic [31:0]       o_instr,
    output logic [ADDR_W-1:0] o_pc,
    output logic              o_valid
);

    logic [31:0]       r_instr;
    logic [ADDR_W-1:0] r_pc;
    logic              r_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr <= NOP_INSTR;
            r_pc    <= '0;
            r_valid <= 1'b0;
        end else if (i_flush) begin
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_instr <= i_instr;
            r_pc    <= i_pc;
            r_valid <= 1'b1;
        end else if (!i_stall) begin
            // consumer took the word and nothing replaced it
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end
    end

    assign o_instr = r_instr;
    assign o_pc    = r_pc;
    assign o_valid = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: owns the PC, runs a single-outstanding
// req/gnt/rvalid fetch, and feeds the IF/ID register to the decoder.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_gnt_i,
    input  logic              imem_rvalid_i,
    input  logic [31:0]       imem_rdata_i,
    input  logic              id_stall_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic [31:0]       instr_o,
    output logic [5:0]        instr_op_o,
    output logic [5:0]        instr_funct_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] pc_plus4_o,
    output logic              instr_valid_o
);

    fetch_state_t      r_state, w_state_next;
    logic [ADDR_W-1:0] r_pc, w_pc_next;
    logic              r_kill, w_kill_next;
    logic [31:0]       r_hold, w_hold_next;

    logic              w_load;
    logic              w_flush;
    logic              w_req;
    logic [31:0]       w_load_instr;
    logic [ADDR_W-1:0] w_pc_plus4;
    logic [ADDR_W-1:0] w_redirect_pc;
    logic [31:0]       w_if_instr;
    logic [ADDR_W-1:0] w_if_pc;
    logic              w_if_valid;

    assign w_pc_plus4    = r_pc + ADDR_W'(4);
    assign w_redirect_pc = redirect_pc_i & ~ADDR_W'(3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_pc    <= RESET_PC;
            r_kill  <= 1'b0;
            r_hold  <= NOP_INSTR;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_kill  <= w_kill_next;
            r_hold  <= w_hold_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_kill_next  = r_kill;
        w_hold_next  = r_hold;
        w_load       = 1'b0;
        w_load_instr = imem_rdata_i;
        w_flush      = 1'b0;
        w_req        = 1'b0;

        case (r_state)
            ST_IDLE: w_state_next = ST_ISSUE;
            ST_ISSUE: begin
                w_req = 1'b1;
                if (imem_gnt_i) w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (imem_rvalid_i) begin
                    if (r_kill) begin
                        w_kill_next  = 1'b0;
                        w_state_next = ST_ISSUE;
                    end else if (!id_stall_i || !w_if_valid) begin
                        w_load       = 1'b1;
                        w_pc_next    = w_pc_plus4;
                        w_state_next = ST_ISSUE;
                    end else begin
                        w_hold_next  = imem_rdata_i;
                        w_state_next = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (!id_stall_i) begin
                    w_load       = 1'b1;
                    w_load_instr = r_hold;
                    w_pc_next    = w_pc_plus4;
                    w_state_next = ST_ISSUE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase

        // A redirect overrides everything; kill only when a response is still owed
        if (redirect_i) begin
            w_load      = 1'b0;
            w_flush     = 1'b1;
            w_pc_next   = w_redirect_pc;
            w_hold_next = NOP_INSTR;
            if ((r_state == ST_WAIT && !imem_rvalid_i) ||
                (r_state == ST_ISSUE && imem_gnt_i)) begin
                w_kill_next  = 1'b1;
                w_state_next = ST_WAIT;
            end else begin
                w_kill_next  = 1'b0;
                w_state_next = ST_ISSUE;
            end
        end
    end

    fetch_stage_if_id_reg #(
        .ADDR_W (ADDR_W)
    ) u_if_id (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_stall (id_stall_i),
        .i_flush (w_flush),
        .i_instr (w_load_instr),
        .i_pc    (r_pc),
        .o_instr (w_if_instr),
        .o_pc    (w_if_pc),
        .o_valid (w_if_valid)
    );

    assign imem_req_o    = w_req;
    assign imem_addr_o   = r_pc;
    assign instr_o       = w_if_instr;
    assign instr_op_o    = w_if_instr[31:26];
    assign instr_funct_o = w_if_instr[5:0];
    assign pc_o          = w_if_pc;
    assign pc_plus4_o    = w_if_pc + ADDR_W'(4);
    assign instr_valid_o = w_if_valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: table-driven sequential fetches plus
// hand-written stall, redirect, wrap and reset sequences, scoreboarded.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0040_0000;

    logic        clk;
    logic        rst_n;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        id_stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] instr_o;
    logic [5:0]  instr_op_o;
    logic [5:0]  instr_funct_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic        instr_valid_o;

    fetch_stage #(
        .ADDR_W   (32),
        .RESET_PC (RST_PC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .id_stall_i    (id_stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_o       (instr_o),
        .instr_op_o    (instr_op_o),
        .instr_funct_o (instr_funct_o),
        .pc_o          (pc_o),
        .pc_plus4_o    (pc_plus4_o),
        .instr_valid_o (instr_valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] word;
        logic [31:0] addr;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    vec_t vecs[4];
    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic check_empty_slot(input string name);
        check({name, "_valid"}, {31'd0, instr_valid_o}, 32'd0);
        check({name, "_instr"}, instr_o, 32'd0);
    endtask

    task automatic wait_req();
        for (int i = 0; i < 8 && !imem_req_o; i++) step();
        check("req_seen", {31'd0, imem_req_o}, 32'd1);
    endtask

    task automatic sb_check_head();
        exp_t e;
        logic [31:0] w;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL sb_empty: got no expected entry, required one");
        end else begin
            e = sb_q.pop_front();
            w = e.instr;
            check("instr", instr_o, e.instr);
            check("pc", pc_o, e.pc);
            check("valid", {31'd0, instr_valid_o}, 32'd1);
            check("op", {26'd0, instr_op_o}, {26'd0, w[31:26]});
            check("funct", {26'd0, instr_funct_o}, {26'd0, w[5:0]});
            check("pc_plus4", pc_plus4_o, e.pc + 32'd4);
        end
    endtask

    // Single-cycle memory: gnt on the request cycle, rvalid the next
    task automatic fetch_one(input logic [31:0] word, input logic [31:0] addr);
        exp_t e;
        wait_req();
        check("req_addr", imem_addr_o, addr);
        $display("fetch addr=%08h word=%08h", addr, word);
        imem_gnt_i = 1'b1;
        step();
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = word;
        e.instr = word;
        e.pc    = addr;
        sb_q.push_back(e);
        step();
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        sb_check_head();
        check("next_addr", imem_addr_o, addr + 32'd4);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] p;
        vecs[0] = '{word: 32'h2008_0005, addr: 32'h0040_0000};
        vecs[1] = '{word: 32'h0109_5020, addr: 32'h0040_0004};
        vecs[2] = '{word: 32'h8D0A_0004, addr: 32'h0040_0008};
        vecs[3] = '{word: 32'h0800_0010, addr: 32'h0040_000C};

        rst_n = 1'b0; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
        id_stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req", {31'd0, imem_req_o}, 32'd0);
        check("rst_pc", pc_o, 32'd0);
        check("rst_addr", imem_addr_o, RST_PC);
        check_empty_slot("rst");
        rst_n = 1'b1;

        // Sequential fetch at full rate
        for (int i = 0; i < 4; i++) fetch_one(vecs[i].word, vecs[i].addr);

        // Decode stall spanning the next response
        p = 32'h0040_0010;
        id_stall_i = 1'b1;
        imem_gnt_i = 1'b1;
        step();
        imem_gnt_i = 1'b0;
        check("stall_wait_instr", instr_o, vecs[3].word);
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'h1234_5678;
        sb_q.push_back('{instr: 32'h1234_5678, pc: p});
        step();
        imem_rvalid_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("hold_req", {31'd0, imem_req_o}, 32'd0);
            check("hold_instr", instr_o, vecs[3].word);
            check("hold_pc", pc_o, vecs[3].addr);
            step();
        end
        check("hold_valid", {31'd0, instr_valid_o}, 32'd1);
        id_stall_i = 1'b0;
        step();
        $display("release addr=%08h word=%08h", p, 32'h1234_5678);
        sb_check_head();
        check("hold_next_addr", imem_addr_o, p + 32'd4);

        // Redirect while waiting; the stale response must be discarded
        imem_gnt_i = 1'b1;
        step();
        imem_gnt_i    = 1'b0;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0040_0103;
        step();
        redirect_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check_empty_slot("kill_wait");
            check("kill_req", {31'd0, imem_req_o}, 32'd0);
            step();
        end
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'hDEAD_BEEF;
        step();
        imem_rvalid_i = 1'b0;
        check_empty_slot("kill_drop");
        check("kill_reissue_req", {31'd0, imem_req_o}, 32'd1);
        check("kill_reissue_addr", imem_addr_o, 32'h0040_0100);
        fetch_one(32'h3C01_1001, 32'h0040_0100);

        // Redirect together with rvalid under stall: flush, no kill
        id_stall_i = 1'b1;
        imem_gnt_i = 1'b1;
        step();
        imem_gnt_i = 1'b0;
        check("rr_held_valid", {31'd0, instr_valid_o}, 32'd1);
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'h0BAD_C0DE;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0040_0200;
        step();
        imem_rvalid_i = 1'b0;
        redirect_i    = 1'b0;
        id_stall_i    = 1'b0;
        check_empty_slot("rr_flush");
        check("rr_req", {31'd0, imem_req_o}, 32'd1);
        check("rr_addr", imem_addr_o, 32'h0040_0200);
        fetch_one(32'h0000_0008, 32'h0040_0200);

        // PC wrap at the top of the address space
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        step();
        redirect_i = 1'b0;
        check("wrap_addr", imem_addr_o, 32'hFFFF_FFFC);
        fetch_one(32'hAC22_0000, 32'hFFFF_FFFC);
        check("wrap_pc_plus4", pc_plus4_o, 32'h0000_0000);

        // Asynchronous reset in the middle of a fetch
        id_stall_i = 1'b1;
        imem_gnt_i = 1'b1;
        step();
        imem_gnt_i = 1'b0;
        check("pre_rst_valid", {31'd0, instr_valid_o}, 32'd1);
        rst_n = 1'b0;
        #1;
        id_stall_i = 1'b0;
        check("arst_req", {31'd0, imem_req_o}, 32'd0);
        check("arst_pc", pc_o, 32'd0);
        check("arst_addr", imem_addr_o, RST_PC);
        check_empty_slot("arst");
        step();
        step();
        rst_n         = 1'b1;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'hFEED_FACE;
        step();
        imem_rvalid_i = 1'b0;
        check_empty_slot("stray");
        check("post_rst_addr", imem_addr_o, RST_PC);
        fetch_one(32'h2402_000A, RST_PC);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
